// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: FSM state encoding, CRC width and default generator.
package crc8_pkg;

  localparam int unsigned CRC_W = 8;
  localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h9B;

  typedef enum logic [1:0] {
    ST_ACCEPT    = 2'd0,
    ST_CALC      = 2'd1,
    ST_EMIT_DATA = 2'd2,
    ST_EMIT_CRC  = 2'd3
  } state_e;

endpackage

// File: rtl/crc8_frame_tx_if.sv
// Byte-stream handshake bundle: upstream payload in, framed bytes out.
interface crc8_frame_tx_if;
  import crc8_pkg::*;

  logic [CRC_W-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [CRC_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  // Environment side: sources payload, sinks framed output.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Framer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/crc8_bit_step.sv
// One-bit CRC-8 update, MSB-first, non-reflected; purely combinational.
module crc8_bit_step
  import crc8_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  input  logic [CRC_W-1:0] poly_i,
  output logic [CRC_W-1:0] crc_o
);

  // Shift left and fold in the generator when the feedback bit is set.
  always_comb begin
    crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ ((crc_i[CRC_W-1] ^ bit_i) ? poly_i : '0);
  end

endmodule

// File: rtl/crc8_frame_tx.sv
// Buffers a payload frame, computes CRC-8 bit-serially, then emits payload followed by CRC.
module crc8_frame_tx
  import crc8_pkg::*;
#(
  parameter int unsigned      MAX_LEN = 16,
  parameter logic [CRC_W-1:0] POLY    = DEFAULT_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  crc8_frame_tx_if.slave        bus,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CRC_W-1:0] sh_q, sh_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             last_q, last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CRC_W-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic [CRC_W-1:0] mem_q [MAX_LEN];
  logic [CRC_W-1:0] crc_step_c;
  logic             in_fire_c;
  logic             out_fire_c;

  assign in_fire_c  = bus.in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && bus.out_ready;

  crc8_bit_step u_bit_step (
    .crc_i  (crc_q),
    .bit_i  (sh_q[CRC_W-1]),
    .poly_i (POLY),
    .crc_o  (crc_step_c)
  );

  // Payload buffer write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && in_fire_c) begin
      mem_q[wr_idx_q] <= bus.in_data;
    end
  end

  // Next-state logic plus next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    crc_d       = crc_q;
    last_d      = last_q;
    overflow_d  = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        if (in_fire_c) begin
          sh_d      = bus.in_data;
          last_d    = bus.in_last;
          bit_cnt_d = 3'd0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        crc_d     = crc_step_c;
        sh_d      = {sh_q[CRC_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // A full buffer closes the frame even without in_last.
          if (last_q || (wr_idx_q == LAST_IDX)) begin
            state_d    = ST_EMIT_DATA;
            rd_idx_d   = '0;
            overflow_d = !last_q;
          end else begin
            state_d  = ST_ACCEPT;
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ST_EMIT_DATA: begin
        if (out_fire_c) begin
          if (rd_idx_q == wr_idx_q) begin
            state_d = ST_EMIT_CRC;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      ST_EMIT_CRC: begin
        if (out_fire_c) begin
          crc_d    = '0;
          wr_idx_d = '0;
          rd_idx_d = '0;
          state_d  = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    in_ready_d  = (state_d == ST_ACCEPT);
    out_valid_d = (state_d == ST_EMIT_DATA) || (state_d == ST_EMIT_CRC);
    out_last_d  = (state_d == ST_EMIT_CRC);
    busy_d      = !((state_d == ST_ACCEPT) && (wr_idx_d == '0));
    unique case (state_d)
      ST_EMIT_DATA: out_data_d = mem_q[rd_idx_d];
      ST_EMIT_CRC:  out_data_d = crc_d;
      default:      out_data_d = '0;
    endcase
  end

  // State and output registers; reset wins over any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      bit_cnt_q   <= 3'd0;
      sh_q        <= '0;
      crc_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      crc_q       <= crc_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Self-checking bench for crc8_frame_tx: vector table + scoreboard + corner sequences.
module tb_crc8_frame_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct packed {
    logic [3:0]      len;
    logic [8:0][7:0] b;
    logic [7:0]      crc;
  } vec_t;

  logic clk;
  logic rst;
  logic busy;
  logic overflow;
  logic rand_ready;

  int total;
  int bad;
  int cyc;
  int ovf_cnt;

  exp_t       sb [$];
  logic [7:0] pay [32];
  vec_t       vecs [4];

  crc8_frame_tx_if bus ();

  crc8_frame_tx #(.MAX_LEN(16), .POLY(8'h9B)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant high or random per cycle.
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference CRC-8: poly 0x9B, init 0, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc_model(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ pay[i][j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h9B : 8'h00);
      end
    end
    return c;
  endfunction

  // Output monitor: scoreboard pops, stall stability, busy/in_ready relations, overflow count.
  logic       stalled;
  logic [7:0] held_d;
  logic       held_l;
  exp_t       e;
  initial stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (stalled) begin
        total++;
        if (!bus.out_valid || bus.out_data !== held_d || bus.out_last !== held_l) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   bus.out_valid, bus.out_data, bus.out_last, held_d, held_l);
        end
      end
      if (!bus.in_ready) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_when_not_ready: got busy=%b, need 1", busy);
        end
      end
      if (bus.out_valid) begin
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL in_ready_during_emit: got %b, need 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got data=%h last=%b, need no output", bus.out_data, bus.out_last);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.d || bus.out_last !== e.l) begin
            bad++;
            $display("FAIL out_byte: got data=%h last=%b, need data=%h last=%b",
                     bus.out_data, bus.out_last, e.d, e.l);
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_l  = bus.out_last;
    end
  end

  // Drive n bytes from pay[]; optionally push payload + model CRC to the scoreboard.
  task automatic send_frame(input int n, input logic fin_last, input logic push, input logic [7:0] crc_exp);
    int   prev;
    logic got;
    if (push) begin
      for (int i = 0; i < n; i++) sb.push_back('{d: pay[i], l: 1'b0});
      sb.push_back('{d: crc_exp, l: 1'b1});
    end
    prev = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pay[i];
      bus.in_last  = (i == n - 1) ? fin_last : 1'b0;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        if (bus.in_ready) got = 1'b1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, need 1 (byte %0d)", i);
        bus.in_valid = 1'b0;
        return;
      end
      if (i > 0) begin
        total++;
        if (cyc - prev != 9) begin
          bad++;
          $display("FAIL accept_spacing: got %0d cycles, need 9", cyc - prev);
        end
      end
      prev = cyc;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b1;
      bus.in_data  = 8'hA5;
    end
  endtask

  // Wait for the scoreboard to drain, then check the block returned to idle.
  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_%s: got %0d pending, need 0", tag, sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_%s: got busy=%b valid=%b ready=%b, need 0 0 1",
               tag, busy, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %b, need %b", name, got, need);
    end
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; ovf_cnt = 0;
    rand_ready   = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '0; vecs[0].len = 4'd1; vecs[0].b[0] = 8'h01; vecs[0].crc = 8'h9B;
    vecs[1] = '0; vecs[1].len = 4'd9; vecs[1].crc = 8'hEA;
    for (int i = 0; i < 9; i++) vecs[1].b[i] = 8'h31 + 8'(i);
    vecs[2] = '0; vecs[2].len = 4'd1; vecs[2].b[0] = 8'h00; vecs[2].crc = 8'h00;
    vecs[3] = '0; vecs[3].len = 4'd1; vecs[3].b[0] = 8'h02; vecs[3].crc = 8'hAD;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_out_last", bus.out_last, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    total++;
    if (bus.out_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_out_data: got %h, need 00", bus.out_data);
    end
    @(posedge clk); #1;

    // Table vectors with known CRC constants.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) pay[i] = vecs[v].b[i];
      send_frame(int'(vecs[v].len), 1'b1, 1'b1, vecs[v].crc);
      wait_drain($sformatf("vec%0d", v));
      @(posedge clk); #1;
    end

    // Random output backpressure on "123456789".
    rand_ready = 1'b1;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    send_frame(9, 1'b1, 1'b1, 8'hEA);
    wait_drain("rand_ready");
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Random frames checked against the reference model.
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
      send_frame(n, 1'b1, 1'b1, crc_model(n));
      wait_drain("random");
      @(posedge clk); #1;
    end

    // 17 bytes without in_last: 16-byte truncated frame, then the 17th starts a new one.
    for (int i = 0; i < 16; i++) pay[i] = 8'h10 + 8'(i);
    send_frame(16, 1'b0, 1'b1, crc_model(16));
    wait_drain("ovf_frame");
    total++;
    if (ovf_cnt != 1) begin
      bad++;
      $display("FAIL overflow_pulses: got %0d, need 1", ovf_cnt);
    end
    @(posedge clk); #1;
    pay[0] = 8'h01;
    send_frame(1, 1'b1, 1'b1, 8'h9B);
    wait_drain("after_ovf");
    @(posedge clk); #1;

    // Reset in the middle of the 3rd byte's CRC calculation; the partial frame must vanish.
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE;
    send_frame(3, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("midrst_in_ready", bus.in_ready, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check1("midrst_no_output", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    pay[0] = 8'h01;
    send_frame(1, 1'b1, 1'b1, 8'h9B);
    wait_drain("after_rst");

    total++;
    if (ovf_cnt != 1) begin
      bad++;
      $display("FAIL overflow_total: got %0d, need 1", ovf_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, need finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
